rca4_adder: RTL and testbench

- 4-bit ripple-carry adder with bit-level operand and sum ports.
- Bit 0 is a half adder with no carry-in; bits 1-3 are full adders chained carry-to-carry.
- The combinational sum and carry feed a single output register stage, so results are synchronous to the system clock.
- Used as a small registered arithmetic leaf; the downstream logic samples S0..S3/Cout one cycle after the operands are applied.

---
 rtl/rca4_adder_pkg.sv | 18 +
 rtl/rca4_adder_full_adder.sv | 16 +
 rtl/rca4_adder.sv | 71 +++++++
 tb/tb_rca4_adder.sv | 104 ++++++++++
 4 files changed

// File: rtl/rca4_adder_pkg.sv
// Shared width constant and result type for the 4-bit registered ripple-carry adder.
package rca4_adder_pkg;

  localparam int unsigned RCA_WIDTH = 4;

  typedef struct packed {
    logic                 cout;
    logic [RCA_WIDTH-1:0] sum;
  } rca_result_t;

  function automatic rca_result_t rca_pack(input logic cout, input logic [RCA_WIDTH-1:0] sum);
    rca_result_t r;
    r.cout = cout;
    r.sum  = sum;
    return r;
  endfunction

endpackage

// File: rtl/rca4_adder_full_adder.sv
// Single-bit full adder used for the upper bits of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rca4_adder.sv
// 4-bit ripple-carry adder with bit-level ports and one output register stage.
module rca4_adder
  import rca4_adder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic Cout,
  output logic out_valid
);

  logic [RCA_WIDTH-1:0] a;
  logic [RCA_WIDTH-1:0] b;
  logic [RCA_WIDTH-1:0] s;
  logic [RCA_WIDTH-1:0] c;

  rca_result_t res_d;
  rca_result_t res_q;
  logic        valid_q;

  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};

  // LSB has no carry-in, so it reduces to a half adder.
  assign s[0] = a[0] ^ b[0];
  assign c[0] = a[0] & b[0];

  for (genvar i = 1; i < RCA_WIDTH; i++) begin : gen_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i-1]),
      .s   (s[i]),
      .cout(c[i])
    );
  end

  always_comb begin
    res_d = rca_pack(c[RCA_WIDTH-1], s);
  end

  // Result register holds across idle cycles; only the valid flag tracks in_valid every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign {S3, S2, S1, S0} = res_q.sum;
  assign Cout             = res_q.cout;
  assign out_valid        = valid_q;

endmodule

// File: tb/tb_rca4_adder.sv
// Directed and randomized bench for rca4_adder against an arithmetic reference model.
module tb_rca4_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic A0 = 1'b0, A1 = 1'b0, A2 = 1'b0, A3 = 1'b0;
  logic B0 = 1'b0, B1 = 1'b0, B2 = 1'b0, B3 = 1'b0;
  logic S0, S1, S2, S3, Cout, out_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [4:0] exp_res = '0;
  logic       exp_v   = 1'b0;

  rca4_adder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .B0       (B0),
    .B1       (B1),
    .B2       (B2),
    .B3       (B3),
    .S0       (S0),
    .S1       (S1),
    .S2       (S2),
    .S3       (S3),
    .Cout     (Cout),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, then check one edge later.
  task automatic cycle(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input string tag);
    logic [4:0] obs;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    if (r) begin
      exp_res = '0;
      exp_v   = 1'b0;
    end else begin
      exp_v = v;
      if (v) exp_res = {1'b0, a} + {1'b0, b};
    end
    @(posedge clk);
    #1;
    obs = {Cout, S3, S2, S1, S0};
    checks++;
    assert (obs === exp_res) else begin
      errors++;
      $error("FAIL %s result observed=%b expected=%b (A=%0d B=%0d)", tag, obs, exp_res, a, b);
    end
    checks++;
    assert (out_valid === exp_v) else begin
      errors++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_v);
    end
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rv, rr;

    ra = 4'($urandom); rb = 4'($urandom);
    cycle(1'b1, 1'b1, ra, rb, "reset0");
    ra = 4'($urandom); rb = 4'($urandom);
    cycle(1'b1, 1'b1, ra, rb, "reset1");

    cycle(1'b0, 1'b1, 4'b1010, 4'b0000, "a10_b0");
    cycle(1'b0, 1'b1, 4'b1011, 4'b1110, "a11_b14");
    cycle(1'b0, 1'b0, 4'b1111, 4'b0001, "hold_after_25");
    cycle(1'b0, 1'b1, 4'b1111, 4'b1111, "full_ripple");
    cycle(1'b0, 1'b0, 4'b0000, 4'b0000, "hold_after_30");

    for (int unsigned i = 0; i < 256; i++) begin
      if (i == 128) begin
        cycle(1'b1, 1'b1, 4'b1111, 4'b0111, "midstream_rst");
      end
      cycle(1'b0, 1'b1, 4'(i), 4'(i >> 4), "exhaustive");
    end

    for (int unsigned k = 0; k < 300; k++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rv = 1'($urandom);
      rr = ($urandom_range(0, 19) == 0);
      cycle(rr, rv, ra, rb, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
